data_mem_responder: RTL and testbench

//  Data-memory responder for the RISC-V core's load/store port: the target end of the core's

---
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/data_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store request/response bundle between the core's data-memory port and the responder.
interface data_mem_responder_if;
    logic        Req;
    logic        Ready;
    logic        WE;
    logic [2:0]  Fun3;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic        RValid;
    logic [31:0] RData;
    logic        Err;

    modport master (
        output Req, WE, Fun3, Addr, WData,
        input  Ready, RValid, RData, Err
    );

    modport slave (
        input  Req, WE, Fun3, Addr, WData,
        output Ready, RValid, RData, Err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder: byte/half/word access to on-chip storage after
// WAIT_CYCLES wait states, one registered response with sign/zero extension and error flag.
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    data_mem_responder_if.slave  bus
);
    localparam int          DEPTH   = 2 ** ADDR_W;
    localparam logic [3:0]  LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [0:DEPTH-1];

    logic        w_ready, w_accept, w_do_access, w_commit;
    logic        w_we;
    logic [2:0]  w_f3;
    logic [31:0] w_addr, w_wdata;
    logic        w_illegal, w_misaligned, w_oob, w_err;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0] w_word, w_load, w_lanes;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_be;

    // With zero wait states the access happens on the accept edge, so the live inputs are used.
    assign w_we    = (r_state == ST_IDLE) ? bus.WE    : r_we;
    assign w_f3    = (r_state == ST_IDLE) ? bus.Fun3  : r_f3;
    assign w_addr  = (r_state == ST_IDLE) ? bus.Addr  : r_addr;
    assign w_wdata = (r_state == ST_IDLE) ? bus.WData : r_wdata;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (bus.Req) w_next = (LP_WAIT == 4'd0) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: if (r_cnt == LP_WAIT) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_accept    = bus.Req && (r_state == ST_IDLE);
    assign w_do_access = (w_next == ST_RESP) && (r_state != ST_RESP);

    always_comb begin
        w_illegal = 1'b0;
        if (w_we) w_illegal = !(w_f3 inside {3'b000, 3'b001, 3'b010});
        else      w_illegal = !(w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end

    assign w_misaligned = ((w_f3[1:0] == 2'b01) && w_addr[0]) ||
                          ((w_f3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
    assign w_oob        = |(w_addr >> (ADDR_W + 2));
    assign w_err        = w_illegal || w_misaligned || w_oob;
    assign w_idx        = w_addr[ADDR_W+1:2];
    assign w_word       = r_mem[w_idx];

    always_comb begin
        w_byte = w_word[7:0];
        case (w_addr[1:0])
            2'd0: w_byte = w_word[7:0];
            2'd1: w_byte = w_word[15:8];
            2'd2: w_byte = w_word[23:16];
            2'd3: w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
        w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];
        case (w_f3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = '0;
        endcase
    end

    always_comb begin
        w_be    = 4'b0000;
        w_lanes = w_wdata;
        case (w_f3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_addr[1:0];
                w_lanes = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{w_wdata[15:0]}};
            end
            2'b10: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Gated by Rst_n because the array has no reset and a zero-wait accept would otherwise commit.
    assign w_commit = w_do_access && w_we && !w_err && Rst_n;

    always_ff @(posedge Clk) begin
        if (w_commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_lanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= 4'd1;
            r_we    <= bus.WE;
            r_f3    <= bus.Fun3;
            r_addr  <= bus.Addr;
            r_wdata <= bus.WData;
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt + 4'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_do_access) begin
            r_rdata <= (w_err || w_we) ? '0 : w_load;
            r_err   <= w_err;
        end else if (r_state == ST_RESP) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end
    end

    assign bus.Ready  = w_ready;
    assign bus.RValid = (r_state == ST_RESP);
    assign bus.RData  = r_rdata;
    assign bus.Err    = r_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized checks of data_mem_responder at 0, 1 and 3 wait states.
module tb_data_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst3;
    data_mem_responder_if if0();
    data_mem_responder_if if1();
    data_mem_responder_if if3();

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u0 (.Clk(clk), .Rst_n(rst0), .bus(if0.slave));
    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u1 (.Clk(clk), .Rst_n(rst1), .bus(if1.slave));
    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u3 (.Clk(clk), .Rst_n(rst3), .bus(if3.slave));

    typedef struct packed {
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } obs_t;

    int total = 0;
    int bad   = 0;
    logic [7:0] mm [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic req, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        case (sel)
            0: begin if0.Req = req; if0.WE = we; if0.Fun3 = f3; if0.Addr = a; if0.WData = wd; end
            1: begin if1.Req = req; if1.WE = we; if1.Fun3 = f3; if1.Addr = a; if1.WData = wd; end
            default: begin if3.Req = req; if3.WE = we; if3.Fun3 = f3; if3.Addr = a; if3.WData = wd; end
        endcase
    endtask

    function automatic obs_t look(input int sel);
        obs_t o;
        case (sel)
            0: o = '{if0.Ready, if0.RValid, if0.RData, if0.Err};
            1: o = '{if1.Ready, if1.RValid, if1.RData, if1.Err};
            default: o = '{if3.Ready, if3.RValid, if3.RData, if3.Err};
        endcase
        return o;
    endfunction

    // One request/response; lat = edges after the accept edge until RValid is seen.
    task automatic xact(input int sel, input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        obs_t o;
        @(negedge clk);
        o = look(sel);
        chk("ready_idle", {31'd0, o.ready}, 32'd1);
        drive(sel, 1'b1, we, f3, a, wd);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        lat = 0;
        o = look(sel);
        while (!o.rvalid && lat < 40) begin
            chk("ready_busy", {31'd0, o.ready}, 32'd0);
            @(posedge clk); #1;
            lat++;
            o = look(sel);
        end
        if (!o.rvalid) chk("rvalid_timeout", {31'd0, o.rvalid}, 32'd1);
        chk("ready_resp", {31'd0, o.ready}, 32'd0);
        rd = o.rdata;
        er = o.err;
        @(posedge clk); #1;
        o = look(sel);
        chk("rvalid_one_cycle", {31'd0, o.rvalid}, 32'd0);
        chk("rdata_clear", o.rdata, 32'd0);
        chk("err_clear", {31'd0, o.err}, 32'd0);
    endtask

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic legal, mis;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = ((f3[1:0] == 2'd1) && (a % 2 != 0)) || ((f3[1:0] == 2'd2) && (a % 4 != 0));
        return !legal || mis || (a >= 32'h1000);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        longint n, v;
        n = longint'(1) << f3[1:0];
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(mm[int'(a) + i]) << (8 * i));
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) mm[int'(a) + i] = 8'((wd >> (8 * i)) & 32'hFF);
    endtask

    initial begin
        logic [31:0] rd, a, wd, exp_rd;
        logic        er, we, exp_er;
        logic [2:0]  f3;
        int          lat, cyc, rv_count;
        int          rv_at[$];
        obs_t        o;

        // Reset held with Req asserted: no accept, outputs at reset values.
        rst0 = 1'b0; rst1 = 1'b0; rst3 = 1'b0;
        drive(0, 1'b1, 1'b1, 3'd2, 32'd0, 32'hFFFF_FFFF);
        drive(1, 1'b1, 1'b1, 3'd2, 32'd0, 32'hFFFF_FFFF);
        drive(3, 1'b1, 1'b1, 3'd2, 32'd0, 32'hFFFF_FFFF);
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            if (s == 2) continue;
            o = look(s);
            chk("rst_ready", {31'd0, o.ready}, 32'd1);
            chk("rst_rvalid", {31'd0, o.rvalid}, 32'd0);
            chk("rst_rdata", o.rdata, 32'd0);
            chk("rst_err", {31'd0, o.err}, 32'd0);
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(3, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        rst0 = 1'b1; rst1 = 1'b1; rst3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        o = look(1);
        chk("post_rst_ready", {31'd0, o.ready}, 32'd1);
        chk("post_rst_rvalid", {31'd0, o.rvalid}, 32'd0);

        // Word store/load round trip.
        xact(1, 1'b1, 3'b010, 32'h100, 32'h1122_3344, rd, er, lat);
        chk("sw_err", {31'd0, er}, 32'd0);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_lat", lat, 32'd1);
        xact(1, 1'b0, 3'b010, 32'h100, 32'd0, rd, er, lat);
        chk("lw_rdata", rd, 32'h1122_3344);
        chk("lw_err", {31'd0, er}, 32'd0);

        // Sub-word stores and extending loads.
        xact(1, 1'b1, 3'b000, 32'h101, 32'h0000_0080, rd, er, lat);
        xact(1, 1'b0, 3'b010, 32'h100, 32'd0, rd, er, lat);
        chk("sb_lw", rd, 32'h1122_8044);
        xact(1, 1'b0, 3'b000, 32'h101, 32'd0, rd, er, lat);
        chk("lb_sign", rd, 32'hFFFF_FF80);
        xact(1, 1'b0, 3'b100, 32'h101, 32'd0, rd, er, lat);
        chk("lbu_zero", rd, 32'h0000_0080);
        xact(1, 1'b1, 3'b001, 32'h102, 32'h0000_BEEF, rd, er, lat);
        xact(1, 1'b0, 3'b101, 32'h102, 32'd0, rd, er, lat);
        chk("lhu_zero", rd, 32'h0000_BEEF);
        xact(1, 1'b0, 3'b001, 32'h102, 32'd0, rd, er, lat);
        chk("lh_sign", rd, 32'hFFFF_BEEF);

        // Error cases leave memory untouched.
        xact(1, 1'b1, 3'b010, 32'h000, 32'h5A5A_5A5A, rd, er, lat);
        xact(1, 1'b0, 3'b010, 32'h102, 32'd0, rd, er, lat);
        chk("lw_mis_err", {31'd0, er}, 32'd1);
        chk("lw_mis_rdata", rd, 32'd0);
        xact(1, 1'b1, 3'b001, 32'h001, 32'h0000_FFFF, rd, er, lat);
        chk("sh_mis_err", {31'd0, er}, 32'd1);
        xact(1, 1'b0, 3'b011, 32'h100, 32'd0, rd, er, lat);
        chk("ld_f3_err", {31'd0, er}, 32'd1);
        chk("ld_f3_rdata", rd, 32'd0);
        xact(1, 1'b0, 3'b010, 32'h1000, 32'd0, rd, er, lat);
        chk("lw_oob_err", {31'd0, er}, 32'd1);
        xact(1, 1'b1, 3'b011, 32'h100, 32'hFFFF_FFFF, rd, er, lat);
        chk("st_f3_err", {31'd0, er}, 32'd1);
        xact(1, 1'b0, 3'b010, 32'h000, 32'd0, rd, er, lat);
        chk("err_no_write0", rd, 32'h5A5A_5A5A);
        xact(1, 1'b0, 3'b010, 32'h100, 32'd0, rd, er, lat);
        chk("err_no_write100", rd, 32'hBEEF_8044);

        // Randomized traffic against the byte-level model in 0x000..0x03F.
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            xact(1, 1'b1, 3'b010, 32'(4 * w), wd, rd, er, lat);
            model_store(3'b010, 32'(4 * w), wd);
        end
        for (int k = 0; k < 80; k++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 19) == 0) a = a | 32'h8000_0000;
            wd = $urandom;
            exp_er = model_err(we, f3, a);
            exp_rd = (exp_er || we) ? 32'd0 : model_load(f3, a);
            if (we && !exp_er) model_store(f3, a, wd);
            xact(1, we, f3, a, wd, rd, er, lat);
            chk("rnd_err", {31'd0, er}, {31'd0, exp_er});
            chk("rnd_rdata", rd, exp_rd);
            chk("rnd_lat", lat, 32'd1);
        end

        // Latency at 0 and 3 wait states.
        xact(0, 1'b1, 3'b010, 32'h10, 32'hCAFE_0001, rd, er, lat);
        chk("lat_w0", lat, 32'd0);
        xact(0, 1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat);
        chk("w0_rdata", rd, 32'hCAFE_0001);
        xact(3, 1'b1, 3'b010, 32'h10, 32'hCAFE_0003, rd, er, lat);
        chk("lat_w3", lat, 32'd3);
        xact(3, 1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat);
        chk("w3_rdata", rd, 32'hCAFE_0003);

        // Req held high: accepts spaced WAIT_CYCLES+2 apart.
        for (int s = 0; s < 4; s += 3) begin
            rv_at.delete();
            @(negedge clk);
            drive(s, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
            for (cyc = 0; cyc < 30; cyc++) begin
                @(posedge clk); #1;
                o = look(s);
                if (o.rvalid) rv_at.push_back(cyc);
            end
            drive(s, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            repeat (8) @(posedge clk);
            chk("b2b_count_ge4", {31'd0, rv_at.size() >= 4}, 32'd1);
            for (int i = 1; i < rv_at.size(); i++)
                chk("b2b_spacing", rv_at[i] - rv_at[i-1], (s == 0) ? 32'd2 : 32'd5);
        end

        // Reset during WAIT discards the pending store.
        xact(3, 1'b1, 3'b010, 32'h200, 32'h1234_5678, rd, er, lat);
        @(negedge clk);
        drive(3, 1'b1, 1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        drive(3, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        rst3 = 1'b0;
        #1;
        o = look(3);
        chk("midrst_ready", {31'd0, o.ready}, 32'd1);
        chk("midrst_rvalid", {31'd0, o.rvalid}, 32'd0);
        @(posedge clk); #1;
        rst3 = 1'b1;
        rv_count = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            o = look(3);
            if (o.rvalid) rv_count++;
        end
        chk("midrst_no_resp", rv_count, 32'd0);
        xact(3, 1'b0, 3'b010, 32'h200, 32'd0, rd, er, lat);
        chk("midrst_preserved", rd, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
